// File: rtl/ysyx_ifu_fetch_resp_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_ifu_fetch_resp_pkg
//   Shared definitions for the IFU fetch responder: AXI4 response and burst
//   codes, the fixed AR size for word fetches, the responder state encoding
//   and small decode helpers.
// ----------------------------------------------------------------------------
package ysyx_ifu_fetch_resp_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_AR,
        FETCH_R,
        FETCH_DRAIN
    } fetch_state_e;

    // Anything other than OKAY is an access fault for a single-beat fetch;
    // EXOKAY is not a legal answer to a non-exclusive read.
    function automatic logic resp_is_error(input logic [1:0] resp);
        case (resp)
            AXI_RESP_OKAY:   return 1'b0;
            AXI_RESP_EXOKAY,
            AXI_RESP_SLVERR,
            AXI_RESP_DECERR: return 1'b1;
            default:         return 1'b1;
        endcase
    endfunction

    function automatic logic word_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_ifu_fetch_resp_if.sv
// ----------------------------------------------------------------------------
// ysyx_ifu_fetch_resp_if
//   Bundles the IFU fetch request/response signals and the AXI4 AR/R channel
//   of the frontend memory port.
//   slave  : the fetch responder (drives out_* signals).
//   master : the IFU plus memory side (drives requests and R-channel beats).
// ----------------------------------------------------------------------------
interface ysyx_ifu_fetch_resp_if #(
    parameter int XLEN = 32
);
    // IFU side
    logic [XLEN-1:0] ifu_araddr;
    logic            ifu_arvalid;
    logic            ifu_required;
    logic [XLEN-1:0] out_ifu_rdata;
    logic            out_ifu_rvalid;
    logic            out_ifu_fault;
    // AXI AR channel
    logic            out_arvalid;
    logic            arready;
    logic [XLEN-1:0] out_araddr;
    logic [3:0]      out_arid;
    logic [7:0]      out_arlen;
    logic [2:0]      out_arsize;
    logic [1:0]      out_arburst;
    // AXI R channel
    logic            rvalid;
    logic            out_rready;
    logic [XLEN-1:0] rdata;
    logic [1:0]      rresp;
    logic            rlast;

    modport slave (
        input  ifu_araddr, ifu_arvalid, ifu_required,
        input  arready, rvalid, rdata, rresp, rlast,
        output out_ifu_rdata, out_ifu_rvalid, out_ifu_fault,
        output out_arvalid, out_araddr, out_arid, out_arlen, out_arsize,
        output out_arburst, out_rready
    );

    modport master (
        output ifu_araddr, ifu_arvalid, ifu_required,
        output arready, rvalid, rdata, rresp, rlast,
        input  out_ifu_rdata, out_ifu_rvalid, out_ifu_fault,
        input  out_arvalid, out_araddr, out_arid, out_arlen, out_arsize,
        input  out_arburst, out_rready
    );
endinterface

// File: rtl/ysyx_ifu_fetch_resp.sv
// ----------------------------------------------------------------------------
// ysyx_ifu_fetch_resp
//   Accepts one word-fetch request at a time from the IFU, issues a single-beat
//   AXI4 read and returns the word as a one-cycle out_ifu_rvalid pulse
//   (out_ifu_fault qualifies it). Abandoned requests still consume their R
//   beat in DRAIN; misaligned addresses fault without any bus access.
//   Ports:
//     clock : rising-edge clock
//     reset : asynchronous active-low reset
//     bus   : IFU request/response + AXI AR/R channels (slave modport)
// ----------------------------------------------------------------------------
module ysyx_ifu_fetch_resp
    import ysyx_ifu_fetch_resp_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int AXI_ID = 0
) (
    input logic                  clock,
    input logic                  reset,
    ysyx_ifu_fetch_resp_if.slave bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] araddr_q, araddr_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            fault_q, fault_d;
    logic            abort_q, abort_d;
    logic            accept;

    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        fault_d  = 1'b0;
        abort_d  = abort_q;
        // The pulse cycle is a forced bubble: no accept while rvalid_q is high.
        accept   = bus.ifu_arvalid & bus.ifu_required & ~rvalid_q;

        case (state_q)
            FETCH_IDLE: begin
                if (accept) begin
                    araddr_d = bus.ifu_araddr;
                    abort_d  = 1'b0;
                    if (word_misaligned(bus.ifu_araddr[1:0])) begin
                        rvalid_d = 1'b1;
                        fault_d  = 1'b1;
                        rdata_d  = '0;
                    end else begin
                        state_d = FETCH_AR;
                    end
                end
            end
            FETCH_AR: begin
                // AR can never be retracted, so an abort seen here is only
                // remembered and acted on once the handshake completes.
                if (!bus.ifu_required) begin
                    abort_d = 1'b1;
                end
                if (bus.arready) begin
                    state_d = (bus.ifu_required && !abort_q) ? FETCH_R : FETCH_DRAIN;
                end
            end
            FETCH_R: begin
                if (bus.rvalid) begin
                    state_d = FETCH_IDLE;
                    if (bus.ifu_required) begin
                        rvalid_d = 1'b1;
                        rdata_d  = bus.rdata;
                        fault_d  = resp_is_error(bus.rresp) | ~bus.rlast;
                    end
                end else if (!bus.ifu_required) begin
                    state_d = FETCH_DRAIN;
                end
            end
            FETCH_DRAIN: begin
                if (bus.rvalid) begin
                    state_d = FETCH_IDLE;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= FETCH_IDLE;
            araddr_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            fault_q  <= fault_d;
            abort_q  <= abort_d;
        end
    end

    // Handshake outputs decode straight from the state flop so that reset
    // drops them asynchronously.
    assign bus.out_arvalid    = (state_q == FETCH_AR);
    assign bus.out_rready     = (state_q == FETCH_R) || (state_q == FETCH_DRAIN);
    assign bus.out_araddr     = araddr_q;
    assign bus.out_arid       = 4'(AXI_ID);
    assign bus.out_arlen      = '0;
    assign bus.out_arsize     = AXI_SIZE_WORD;
    assign bus.out_arburst    = AXI_BURST_INCR;
    assign bus.out_ifu_rdata  = rdata_q;
    assign bus.out_ifu_rvalid = rvalid_q;
    assign bus.out_ifu_fault  = fault_q;

endmodule

// File: tb/tb_ysyx_ifu_fetch_resp.sv
// ----------------------------------------------------------------------------
// tb_ysyx_ifu_fetch_resp
//   Directed bench for ysyx_ifu_fetch_resp: plays both the IFU and the AXI
//   memory slave with hand-timed vectors, and counts IFU pulses independently
//   to catch spurious or missing responses.
// ----------------------------------------------------------------------------
module tb_ysyx_ifu_fetch_resp;
    import ysyx_ifu_fetch_resp_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   pulses     = 0;
    int   exp_pulses = 0;

    always #5 clk = ~clk;

    ysyx_ifu_fetch_resp_if #(.XLEN(32)) bus ();

    ysyx_ifu_fetch_resp #(
        .XLEN   (32),
        .AXI_ID (5)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_ifu_rvalid === 1'b1) pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h0000_0013 ^ (addr * 32'h0009_E37B);
    endfunction

    // Starts in the first AR cycle; optionally chains a request to addr+4
    // during the pulse so the bubble can be observed (returns with it held).
    task automatic finish_fetch(input logic [31:0] addr, input int ar_wait, input int r_wait,
                                input logic [31:0] data, input logic [1:0] resp,
                                input logic last, input logic exp_fault, input logic chain);
        for (int i = 0; i < ar_wait; i++) begin
            check("ar_hold_valid", 32'(bus.out_arvalid), 32'd1);
            check("ar_hold_addr", bus.out_araddr, addr);
            step();
        end
        check("arvalid", 32'(bus.out_arvalid), 32'd1);
        check("araddr", bus.out_araddr, addr);
        check("arlen", 32'(bus.out_arlen), 32'd0);
        check("arsize", 32'(bus.out_arsize), 32'd2);
        check("arburst", 32'(bus.out_arburst), 32'd1);
        check("arid", 32'(bus.out_arid), 32'd5);
        bus.arready = 1'b1;
        step();
        bus.arready = 1'b0;
        check("ar_dropped", 32'(bus.out_arvalid), 32'd0);
        for (int i = 0; i < r_wait; i++) begin
            check("r_wait_ready", 32'(bus.out_rready), 32'd1);
            check("no_early_pulse", 32'(bus.out_ifu_rvalid), 32'd0);
            step();
        end
        check("rready", 32'(bus.out_rready), 32'd1);
        bus.rvalid = 1'b1;
        bus.rdata  = data;
        bus.rresp  = resp;
        bus.rlast  = last;
        step();
        bus.rvalid = 1'b0;
        check("pulse", 32'(bus.out_ifu_rvalid), 32'd1);
        check("pulse_rdata", bus.out_ifu_rdata, data);
        check("pulse_fault", 32'(bus.out_ifu_fault), 32'(exp_fault));
        check("rready_off", 32'(bus.out_rready), 32'd0);
        exp_pulses++;
        if (chain) begin
            bus.ifu_araddr  = addr + 32'd4;
            bus.ifu_arvalid = 1'b1;
        end
        step();
        check("pulse_single", 32'(bus.out_ifu_rvalid), 32'd0);
        check("fault_idle", 32'(bus.out_ifu_fault), 32'd0);
        check("rdata_hold", bus.out_ifu_rdata, data);
        if (chain) check("bubble_no_ar", 32'(bus.out_arvalid), 32'd0);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input int ar_wait, input int r_wait,
                            input logic [31:0] data, input logic [1:0] resp,
                            input logic last, input logic exp_fault);
        bus.ifu_araddr   = addr;
        bus.ifu_arvalid  = 1'b1;
        bus.ifu_required = 1'b1;
        step();
        bus.ifu_arvalid  = 1'b0;
        finish_fetch(addr, ar_wait, r_wait, data, resp, last, exp_fault, 1'b0);
    endtask

    initial begin
        logic [31:0] a;
        rst_n            = 1'b0;
        bus.ifu_araddr   = '0;
        bus.ifu_arvalid  = 1'b0;
        bus.ifu_required = 1'b1;
        bus.arready      = 1'b0;
        bus.rvalid       = 1'b0;
        bus.rdata        = '0;
        bus.rresp        = AXI_RESP_OKAY;
        bus.rlast        = 1'b1;
        #2;
        check("rst_arvalid", 32'(bus.out_arvalid), 32'd0);
        check("rst_rready", 32'(bus.out_rready), 32'd0);
        check("rst_ifu_rvalid", 32'(bus.out_ifu_rvalid), 32'd0);
        check("rst_fault", 32'(bus.out_ifu_fault), 32'd0);
        check("rst_rdata", bus.out_ifu_rdata, 32'd0);
        check("rst_araddr", bus.out_araddr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Immediate slave: pulse three cycles after accept.
        do_fetch(32'h8000_0000, 0, 0, 32'h0000_0413, AXI_RESP_OKAY, 1'b1, 1'b0);

        // Backpressure, then ifu_arvalid held through the pulse.
        bus.ifu_araddr  = 32'h8000_0010;
        bus.ifu_arvalid = 1'b1;
        step();
        bus.ifu_arvalid = 1'b0;
        finish_fetch(32'h8000_0010, 5, 7, 32'h0041_0113, AXI_RESP_OKAY, 1'b1, 1'b0, 1'b1);
        step();
        bus.ifu_arvalid = 1'b0;
        finish_fetch(32'h8000_0014, 0, 1, 32'h0080_0193, AXI_RESP_OKAY, 1'b1, 1'b0, 1'b0);

        // Abort after the AR handshake: beat drained, no pulse.
        bus.ifu_araddr  = 32'h8000_0008;
        bus.ifu_arvalid = 1'b1;
        step();
        bus.ifu_arvalid = 1'b0;
        bus.arready     = 1'b1;
        check("abort_arvalid", 32'(bus.out_arvalid), 32'd1);
        step();
        bus.arready = 1'b0;
        check("abort_r_rready", 32'(bus.out_rready), 32'd1);
        step();
        bus.ifu_required = 1'b0;
        step();
        check("drain_rready", 32'(bus.out_rready), 32'd1);
        step();
        step();
        check("drain_wait_rready", 32'(bus.out_rready), 32'd1);
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h1234_5678;
        step();
        bus.rvalid       = 1'b0;
        bus.ifu_required = 1'b1;
        check("abort_no_pulse", 32'(bus.out_ifu_rvalid), 32'd0);
        check("drain_done", 32'(bus.out_rready), 32'd0);
        do_fetch(32'h8000_0004, 1, 1, mem_word(32'h8000_0004), AXI_RESP_OKAY, 1'b1, 1'b0);

        // Abort while AR waits, required returns before the handshake.
        bus.ifu_araddr  = 32'h8000_000C;
        bus.ifu_arvalid = 1'b1;
        step();
        bus.ifu_arvalid  = 1'b0;
        bus.ifu_required = 1'b0;
        step();
        check("ar_abort_hold", 32'(bus.out_arvalid), 32'd1);
        bus.ifu_required = 1'b1;
        bus.arready      = 1'b1;
        step();
        bus.arready = 1'b0;
        check("ar_abort_rready", 32'(bus.out_rready), 32'd1);
        bus.rvalid = 1'b1;
        step();
        bus.rvalid = 1'b0;
        check("ar_abort_no_pulse", 32'(bus.out_ifu_rvalid), 32'd0);
        check("ar_abort_idle", 32'(bus.out_rready), 32'd0);

        // required drops in the same cycle as the R beat.
        bus.ifu_araddr  = 32'h8000_0014;
        bus.ifu_arvalid = 1'b1;
        step();
        bus.ifu_arvalid = 1'b0;
        bus.arready     = 1'b1;
        step();
        bus.arready      = 1'b0;
        bus.rvalid       = 1'b1;
        bus.ifu_required = 1'b0;
        step();
        bus.rvalid       = 1'b0;
        bus.ifu_required = 1'b1;
        check("same_cycle_no_pulse", 32'(bus.out_ifu_rvalid), 32'd0);
        check("same_cycle_idle", 32'(bus.out_rready), 32'd0);

        // Bus faults.
        do_fetch(32'h8000_0018, 1, 2, 32'hDEAD_BEEF, AXI_RESP_SLVERR, 1'b1, 1'b1);
        do_fetch(32'h8000_001C, 0, 0, 32'h0010_0073, AXI_RESP_OKAY, 1'b0, 1'b1);
        do_fetch(32'h8000_0020, 0, 0, 32'hCAFE_F00D, AXI_RESP_DECERR, 1'b1, 1'b1);

        // Misaligned fetch: immediate fault, no AR.
        bus.ifu_araddr  = 32'h8000_0002;
        bus.ifu_arvalid = 1'b1;
        step();
        bus.ifu_arvalid = 1'b0;
        check("misalign_no_ar", 32'(bus.out_arvalid), 32'd0);
        check("misalign_pulse", 32'(bus.out_ifu_rvalid), 32'd1);
        check("misalign_fault", 32'(bus.out_ifu_fault), 32'd1);
        check("misalign_rdata", bus.out_ifu_rdata, 32'd0);
        exp_pulses++;
        step();
        check("misalign_still_no_ar", 32'(bus.out_arvalid), 32'd0);
        check("misalign_single", 32'(bus.out_ifu_rvalid), 32'd0);

        // Unsolicited rvalid in IDLE.
        bus.rvalid = 1'b1;
        #1;
        check("unsolicited_rready", 32'(bus.out_rready), 32'd0);
        step();
        bus.rvalid = 1'b0;
        check("unsolicited_no_pulse", 32'(bus.out_ifu_rvalid), 32'd0);

        // Load rdata with a known value, then reset asynchronously mid-R.
        do_fetch(32'h8000_0024, 0, 0, 32'h5555_AAAA, AXI_RESP_OKAY, 1'b1, 1'b0);
        bus.ifu_araddr  = 32'h8000_0028;
        bus.ifu_arvalid = 1'b1;
        step();
        bus.ifu_arvalid = 1'b0;
        bus.arready     = 1'b1;
        step();
        bus.arready = 1'b0;
        check("pre_reset_rready", 32'(bus.out_rready), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_arvalid", 32'(bus.out_arvalid), 32'd0);
        check("async_rst_rready", 32'(bus.out_rready), 32'd0);
        check("async_rst_rvalid", 32'(bus.out_ifu_rvalid), 32'd0);
        check("async_rst_fault", 32'(bus.out_ifu_fault), 32'd0);
        check("async_rst_araddr", bus.out_araddr, 32'd0);
        check("async_rst_rdata", bus.out_ifu_rdata, 32'd0);
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hBAD0_BAD0;
        #2;
        rst_n = 1'b1;
        step();
        check("stale_rready", 32'(bus.out_rready), 32'd0);
        check("stale_no_pulse", 32'(bus.out_ifu_rvalid), 32'd0);
        bus.rvalid = 1'b0;
        step();
        check("stale_no_pulse2", 32'(bus.out_ifu_rvalid), 32'd0);

        // Back-to-back sequential fetches against a random-latency slave.
        for (int i = 0; i < 16; i++) begin
            a = 32'h8000_0000 + 32'(i) * 32'd4;
            do_fetch(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     mem_word(a), AXI_RESP_OKAY, 1'b1, 1'b0);
        end

        step();
        check("pulse_count", 32'(pulses), 32'(exp_pulses));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
